// File: rtl/tff_seq_pkg.sv
// Shared definitions for the T flip-flop sequencer: state encodings and default bank width.
package tff_seq_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [2:0] StateIdle  = 3'd0;
  localparam logic [2:0] StateClear = 3'd1;
  localparam logic [2:0] StateRun   = 3'd2;
  localparam logic [2:0] StatePause = 3'd3;
  localparam logic [2:0] StateDone  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = StateIdle,
    StClear = StateClear,
    StRun   = StateRun,
    StPause = StatePause,
    StDone  = StateDone
  } state_e;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops; each bit flips on a rising clock edge when its toggle enable is set.
module tff_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_sequencer.sv
// Sequencer that counts a T flip-flop bank up to, or down from, a captured limit using only
// per-bit toggle enables.
module tff_sequencer
  import tff_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] step_t;
  logic [WIDTH-1:0] term;
  logic             capture;
  logic             carry;

  tff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .t    (t),
    .q    (q)
  );

  // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    step_t = '0;
    carry  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      step_t[i] = carry;
      carry     = carry & (q[i] ^ dir_q);
    end
  end

  always_comb begin
    state_d = state_q;
    t       = '0;
    capture = 1'b0;
    term    = dir_q ? '0 : limit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          t       = dir_q ? (q ^ limit_q) : q;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (q == term) begin
          state_d = StDone;
        end else if (pause) begin
          state_d = StPause;
        end else begin
          t = step_t;
        end
      end
      StPause: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        dir_q   <= dir;
        limit_q <= limit;
      end
    end
  end

  assign busy = (state_q == StClear) || (state_q == StRun) || (state_q == StPause);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_tff_sequencer.sv
// Self-checking bench for tff_sequencer: directed scenarios plus randomized traffic against a
// counting reference model.
module tb_tff_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         dir;
  logic [W-1:0] limit;
  logic         pause;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: an integer count that moves by +/-1 toward its target.
  bit m_busy, m_preset, m_held, m_done, m_up;
  int m_q, m_lim;

  tff_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .dir  (dir),
    .limit(limit),
    .pause(pause),
    .abort(abort),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_preset = 0; m_held = 0; m_done = 0; m_up = 1;
    m_q = 0; m_lim = 0;
  endtask

  task automatic model_edge();
    int tgt;
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_preset = 1; m_held = 0;
        m_up = !dir; m_lim = int'(limit);
      end
    end else if (abort) begin
      m_busy = 0; m_preset = 0; m_held = 0;
    end else if (m_preset) begin
      m_q = m_up ? 0 : m_lim;
      m_preset = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else begin
      tgt = m_up ? m_lim : 0;
      if (m_q == tgt) begin
        m_busy = 0; m_done = 1;
      end else if (pause) begin
        m_held = 1;
      end else begin
        m_q = m_up ? m_q + 1 : m_q - 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_eq("q", 32'(q), 32'(m_q));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
  endtask

  task automatic begin_seq(input bit d, input int l, output int e0);
    start = 1'b1;
    dir   = d;
    limit = W'(l);
    step();
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic run_to_done(input int e0, output int k);
    bit found;
    found = 0;
    k = -1;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (done === 1'b1) begin
        found = 1;
        k = cyc - e0;
      end
    end
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq({tag, "_q"}, 32'(q), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int e0, k;
    reset = 1'b1; start = 1'b0; dir = 1'b0; limit = '0; pause = 1'b0; abort = 1'b0;
    model_reset();
    #12;
    check_eq("rst_q", 32'(q), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    // Up count to 5.
    begin_seq(1'b0, 5, e0);
    check_eq("up_busy_e0", 32'(busy), 32'd1);
    run_to_done(e0, k);
    check_eq("up_done_lat", 32'(k), 32'd7);
    check_eq("up_q_final", 32'(q), 32'd5);
    step();
    check_eq("up_busy_fall", 32'(busy), 32'd0);
    check_eq("up_q_hold", 32'(q), 32'd5);

    // Down count from 3 with the bank starting at 5.
    begin_seq(1'b1, 3, e0);
    step();
    check_eq("dn_preset", 32'(q), 32'd3);
    run_to_done(e0, k);
    check_eq("dn_done_lat", 32'(k), 32'd5);
    check_eq("dn_q_final", 32'(q), 32'd0);
    step();

    // Start while busy is ignored.
    begin_seq(1'b0, 6, e0);
    step();
    step();
    start = 1'b1; dir = 1'b1; limit = W'(2);
    step();
    start = 1'b0;
    run_to_done(e0, k);
    check_eq("busy_start_lat", 32'(k), 32'd8);
    check_eq("busy_start_q", 32'(q), 32'd6);
    step();

    // Pause for four edges while q is 4.
    begin_seq(1'b0, 10, e0);
    for (int i = 0; i < 20 && q !== W'(4); i++) step();
    pause = 1'b1;
    repeat (4) step();
    check_eq("pause_hold", 32'(q), 32'd4);
    pause = 1'b0;
    run_to_done(e0, k);
    check_eq("pause_done_lat", 32'(k), 32'd17);
    check_eq("pause_q_final", 32'(q), 32'd10);
    step();

    // Abort at 37, then zero-length sequences in both directions.
    begin_seq(1'b0, 200, e0);
    for (int i = 0; i < 60 && q !== W'(37); i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_q", 32'(q), 32'd37);
    repeat (3) step();
    begin_seq(1'b0, 0, e0);
    run_to_done(e0, k);
    check_eq("zero_up_lat", 32'(k), 32'd2);
    check_eq("zero_up_q", 32'(q), 32'd0);
    step();
    begin_seq(1'b1, 0, e0);
    run_to_done(e0, k);
    check_eq("zero_dn_lat", 32'(k), 32'd2);
    step();

    // Asynchronous reset mid-run, then a clean sequence.
    begin_seq(1'b0, 50, e0);
    repeat (10) step();
    async_reset_pulse("async_rst");
    begin_seq(1'b0, 5, e0);
    run_to_done(e0, k);
    check_eq("post_rst_lat", 32'(k), 32'd7);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      dir   = 1'($urandom_range(0, 1));
      limit = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 15));
      pause = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse("rand_rst");
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tff_sequencer.md
TFF_SEQUENCER -- requirements
Module: tff_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of T flip-flops in the sequenced bank.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a count sequence; sampled only in IDLE.
REQ-005 SHALL have port dir, input, 1 bit: 0 = count up to limit, 1 = count down from limit; captured at accepted start.
REQ-006 SHALL have port limit, input, WIDTH bits: terminal (up) or preset (down) value; captured at accepted start.
REQ-007 SHALL have port pause, input, 1 bit: level-sensitive hold request.
REQ-008 SHALL have port abort, input, 1 bit: cancel the sequence and return to IDLE.
REQ-009 SHALL have port q, output, WIDTH bits: current Q of the flip-flop bank.
REQ-010 SHALL have port busy, output, 1 bit: high in CLEAR, RUN and PAUSE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on sequence completion.

Function
REQ-012 SHALL change the bank contents only through per-bit toggle enables t[WIDTH-1:0]; there is no direct load of the bank.
REQ-013 SHALL implement the states IDLE, CLEAR, RUN, PAUSE and DONE.
REQ-014 IDLE SHALL drive t=0; start=1 SHALL capture dir and limit and move to CLEAR; start outside IDLE SHALL be ignored.
REQ-015 CLEAR SHALL last one cycle and preset the bank: up drives t=q (bank becomes 0); down drives t=q^limit (bank becomes limit). Next state SHALL be RUN.
REQ-016 RUN SHALL check the terminal value first: up terminal = captured limit; down terminal = 0. If q equals the terminal, RUN SHALL drive t=0 and move to DONE.
REQ-017 Otherwise, with pause=1, RUN SHALL drive t=0 and move to PAUSE; terminal detection SHALL take precedence over pause.
REQ-018 Otherwise RUN SHALL step the bank by one.
- Up: t[0]=1; t[i]=&q[i-1:0].
- Down: t[0]=1; t[i]=&~q[i-1:0].
REQ-019 PAUSE SHALL drive t=0; pause=0 SHALL return to RUN, and that transition cycle SHALL not toggle.
REQ-020 DONE SHALL drive t=0, assert done for exactly one cycle and return to IDLE.
REQ-021 abort=1 in CLEAR, RUN or PAUSE SHALL drive t=0 that cycle and go to IDLE with no done pulse; q SHALL retain its value; abort SHALL take precedence over all other inputs.
REQ-022 Latency SHALL be fixed. With E0 the edge that accepts start:
- q holds the preset after E0+1.
- done is high between E0+limit+2 and E0+limit+3 when no pause occurs.
- busy rises after E0 and falls after E0+limit+2.
REQ-023 The counter SHALL never wrap, since RUN stops at the terminal. limit=0 SHALL complete with done at E0+2, for both directions.
REQ-024 A pause held for N sampled RUN/PAUSE edges SHALL delay done by exactly N+1 cycles.

Reset
REQ-025 reset=1 SHALL immediately force:
- state to IDLE;
- q, the captured dir and the captured limit to 0;
- busy and done to 0.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence without a done pulse; the first start after deassertion SHALL behave per REQ-022.

Structure
REQ-027 Shared package tff_seq_pkg SHALL hold the state encodings (3-bit localparams) and the default WIDTH.
REQ-028 The bank SHALL be a sub-module tff_bank: WIDTH T flip-flops with inputs clk, reset (async high) and t[WIDTH-1:0], and output q. tff_sequencer SHALL contain only the FSM, the capture registers and the toggle-vector logic.

Verification
REQ-029 Up count: dir=0, limit=5, start at E0 -> q goes 0,1,2,3,4,5; done pulses at E0+7; busy then falls; q stays 5.
REQ-030 Down count: dir=1, limit=3, q initially 5 -> CLEAR loads 3; q goes 2,1,0; done at E0+5.
REQ-031 Pause: dir=0, limit=10, pause high for 4 edges while q=4 -> q holds 4; done at E0+12+5=E0+17; final q=10.
REQ-032 Abort: dir=0, limit=200, abort at q=37 -> IDLE next cycle; no done; q stays 37. Then start with limit=0 -> done at E0+2 and q=0.
REQ-033 Robustness:
- start pulsed while busy is ignored and the sequence is unchanged.
- Async reset mid-RUN clears q, busy and done without waiting for a clock edge.
